// File: rtl/hand_command_gen.sv
// hand_command_gen: converts left/right hand coordinates into throttle/roll/pitch
// drone commands. Arm/disarm FSM, dead-zone substitution, loss-of-tracking
// watchdog (hover command) and a two-stage arithmetic pipeline (latency N+2).
// Optional macro HAND_CMD_SMOOTH_EN: 4-tap moving-average filter on the
// command values, adding one register stage (latency N+3).
module hand_command_gen #(
  parameter int unsigned DEAD_Y         = 512,
  parameter int unsigned THR_SHIFT      = 1,
  parameter int unsigned ROLL_SHIFT     = 2,
  parameter int unsigned PITCH_SHIFT    = 4,
  parameter int unsigned Z_CENTER       = 2048,
  parameter int unsigned ARM_FRAMES     = 8,
  parameter int unsigned DISARM_FRAMES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 6500000,
  parameter int unsigned HOVER_THR      = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_valid,
  input  logic [15:0]       left_x,
  input  logic [15:0]       left_y,
  input  logic [15:0]       left_z,
  input  logic [15:0]       right_x,
  input  logic [15:0]       right_y,
  input  logic [15:0]       right_z,
  output logic              cmd_valid,
  output logic [7:0]        throttle,
  output logic signed [7:0] roll,
  output logic signed [7:0] pitch,
  output logic              armed
);

  localparam int unsigned AW = $clog2(ARM_FRAMES + 1);
  localparam int unsigned DW = $clog2(DISARM_FRAMES + 1);
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0]        DEAD_Y16 = 16'(DEAD_Y);
  localparam logic signed [17:0] DEAD_Y18 = 18'(DEAD_Y);
  localparam logic signed [17:0] ZC18     = 18'(Z_CENTER);
  localparam logic [AW-1:0]      ARM_N    = AW'(ARM_FRAMES);
  localparam logic [DW-1:0]      DIS_LAST = DW'(DISARM_FRAMES - 1);
  localparam logic [WW-1:0]      TO_LAST  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]         HOVER8   = 8'(HOVER_THR);

  typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, HOVER} state_t;

  state_t        state, state_next;
  logic [AW-1:0] arm_cnt, arm_next, arm_inc;
  logic [DW-1:0] dis_cnt, dis_next;
  logic [WW-1:0] wdog, wdog_next;
  logic          l_dead, r_dead, qual, both_dead, emit, hover_fire;
  logic          unused_x;

  logic               s1_valid, s1_bd;
  logic [15:0]        s1_ly, s1_ry, s1_lz, s1_rz;
  logic signed [17:0] sum_y, avg_y, thr_raw, roll_raw, sum_z, avg_z, pitch_raw;
  logic [7:0]         thr_c;
  logic signed [7:0]  roll_c, pitch_c;

  function automatic logic [7:0] sat_u8(input logic signed [17:0] v);
    if (v < 18'sd0)        return 8'd0;
    else if (v > 18'sd255) return 8'd255;
    else                   return v[7:0];
  endfunction

  function automatic logic signed [7:0] sat_s8(input logic signed [17:0] v);
    if (v > 18'sd127)       return 8'sd127;
    else if (v < -18'sd127) return -8'sd127;
    else                    return v[7:0];
  endfunction

  // Dead-zone classification of the incoming frame
  always_comb begin
    unused_x  = ^{left_x, right_x};
    l_dead    = (left_y >= DEAD_Y16);
    r_dead    = (right_y >= DEAD_Y16);
    qual      = !l_dead && !r_dead;
    both_dead = l_dead && r_dead;
  end

  // State register with arm, disarm and watchdog counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      arm_cnt <= '0;
      dis_cnt <= '0;
      wdog    <= '0;
    end else begin
      state   <= state_next;
      arm_cnt <= arm_next;
      dis_cnt <= dis_next;
      wdog    <= wdog_next;
    end
  end

  // Next-state logic: arming qualification, disarm counting, watchdog expiry
  always_comb begin
    state_next = state;
    arm_next   = arm_cnt;
    dis_next   = dis_cnt;
    wdog_next  = '0;
    emit       = 1'b0;
    hover_fire = 1'b0;
    arm_inc    = arm_cnt + 1'b1;
    unique case (state)
      IDLE, ARMING: begin
        if (frame_valid) begin
          if (!qual) begin
            state_next = IDLE;
            arm_next   = '0;
          end else if (arm_inc == ARM_N) begin
            state_next = ACTIVE;
            arm_next   = '0;
            emit       = 1'b1;
          end else begin
            state_next = ARMING;
            arm_next   = arm_inc;
          end
        end
      end
      ACTIVE, HOVER: begin
        if (frame_valid) begin
          emit       = 1'b1;
          state_next = ACTIVE;
          if (!both_dead) begin
            dis_next = '0;
          end else if (dis_cnt == DIS_LAST) begin
            state_next = IDLE;
            dis_next   = '0;
          end else begin
            dis_next = dis_cnt + 1'b1;
          end
        end else if (state == ACTIVE) begin
          // wdog reads k-1 in the k-th cycle after a frame, so expiry lands
          // on cycle TIMEOUT_CYCLES and the hover command one cycle later
          if (wdog == TO_LAST) begin
            hover_fire = 1'b1;
            state_next = HOVER;
          end else begin
            wdog_next = wdog + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    armed = (state == ACTIVE) || (state == HOVER);
  end

`ifdef HAND_CMD_SMOOTH_EN
  logic s1_first;
`endif

  // Stage 1: latch the frame with dead-hand y substitution
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_bd    <= 1'b0;
      s1_ly    <= '0;
      s1_ry    <= '0;
      s1_lz    <= '0;
      s1_rz    <= '0;
`ifdef HAND_CMD_SMOOTH_EN
      s1_first <= 1'b0;
`endif
    end else begin
      s1_valid <= emit;
      if (emit) begin
        s1_bd <= both_dead;
        s1_ly <= (l_dead && !r_dead) ? right_y : left_y;
        s1_ry <= (r_dead && !l_dead) ? left_y : right_y;
        s1_lz <= left_z;
        s1_rz <= right_z;
`ifdef HAND_CMD_SMOOTH_EN
        s1_first <= (state != ACTIVE);
`endif
      end
    end
  end

  // Stage 2 arithmetic on 18-bit signed intermediates
  always_comb begin
    sum_y     = $signed({2'b00, s1_ly}) + $signed({2'b00, s1_ry});
    avg_y     = sum_y >>> 1;
    thr_raw   = (DEAD_Y18 - avg_y) >>> THR_SHIFT;
    roll_raw  = ($signed({2'b00, s1_ly}) - $signed({2'b00, s1_ry})) >>> ROLL_SHIFT;
    sum_z     = $signed({2'b00, s1_lz}) + $signed({2'b00, s1_rz});
    avg_z     = sum_z >>> 1;
    pitch_raw = (avg_z - ZC18) >>> PITCH_SHIFT;
    thr_c     = s1_bd ? 8'd0 : sat_u8(thr_raw);
    roll_c    = s1_bd ? 8'sd0 : sat_s8(roll_raw);
    pitch_c   = s1_bd ? 8'sd0 : sat_s8(pitch_raw);
  end

`ifdef HAND_CMD_SMOOTH_EN
  logic              s2_valid, s2_bd, s2_first, pend, pre;
  logic [7:0]        s2_thr;
  logic signed [7:0] s2_roll, s2_pitch;
  logic [7:0]        h_thr [3];
  logic signed [7:0] h_roll [3];
  logic signed [7:0] h_pitch [3];
  logic [9:0]        thr_sum;
  logic signed [9:0] roll_sum, pitch_sum;

  // Stage 2 register holding the unfiltered command
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_bd    <= 1'b0;
      s2_first <= 1'b0;
      s2_thr   <= '0;
      s2_roll  <= '0;
      s2_pitch <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_bd    <= s1_bd;
        s2_first <= s1_first;
        s2_thr   <= thr_c;
        s2_roll  <= roll_c;
        s2_pitch <= pitch_c;
      end
    end
  end

  // Four-tap sums over the new sample and the three previous history entries
  always_comb begin
    pre       = s2_first | pend;
    thr_sum   = {2'b00, s2_thr} + {2'b00, h_thr[0]} + {2'b00, h_thr[1]} + {2'b00, h_thr[2]};
    roll_sum  = {{2{s2_roll[7]}}, s2_roll} + {{2{h_roll[0][7]}}, h_roll[0]}
              + {{2{h_roll[1][7]}}, h_roll[1]} + {{2{h_roll[2][7]}}, h_roll[2]};
    pitch_sum = {{2{s2_pitch[7]}}, s2_pitch} + {{2{h_pitch[0][7]}}, h_pitch[0]}
              + {{2{h_pitch[1][7]}}, h_pitch[1]} + {{2{h_pitch[2][7]}}, h_pitch[2]};
  end

  // Stage 3: filtered output; a preload pending across a both-dead frame is
  // applied to the next live sample so stale history never leaks out
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      throttle  <= '0;
      roll      <= '0;
      pitch     <= '0;
      pend      <= 1'b0;
      h_thr     <= '{default: '0};
      h_roll    <= '{default: '0};
      h_pitch   <= '{default: '0};
    end else begin
      cmd_valid <= s2_valid | hover_fire;
      if (s2_valid) begin
        if (s2_bd) begin
          throttle <= '0;
          roll     <= '0;
          pitch    <= '0;
          if (s2_first) pend <= 1'b1;
        end else begin
          pend <= 1'b0;
          if (pre) begin
            throttle <= s2_thr;
            roll     <= s2_roll;
            pitch    <= s2_pitch;
            h_thr    <= '{s2_thr, s2_thr, s2_thr};
            h_roll   <= '{s2_roll, s2_roll, s2_roll};
            h_pitch  <= '{s2_pitch, s2_pitch, s2_pitch};
          end else begin
            throttle <= thr_sum[9:2];
            roll     <= roll_sum[9:2];
            pitch    <= pitch_sum[9:2];
            h_thr    <= '{h_thr[1], h_thr[0], s2_thr};
            h_roll   <= '{h_roll[1], h_roll[0], s2_roll};
            h_pitch  <= '{h_pitch[1], h_pitch[0], s2_pitch};
          end
        end
      end else if (hover_fire) begin
        throttle <= HOVER8;
        roll     <= '0;
        pitch    <= '0;
      end
    end
  end
`else
  // Stage 2 register: frame commands take priority over a colliding hover
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      throttle  <= '0;
      roll      <= '0;
      pitch     <= '0;
    end else begin
      cmd_valid <= s1_valid | hover_fire;
      if (s1_valid) begin
        throttle <= thr_c;
        roll     <= roll_c;
        pitch    <= pitch_c;
      end else if (hover_fire) begin
        throttle <= HOVER8;
        roll     <= '0;
        pitch    <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hand_command_gen.sv
// tb_hand_command_gen: directed stimulus with a scoreboard queue; a monitor
// pops and compares every cmd_valid strobe (values and arrival cycle).
`timescale 1ns/1ps
module tb_hand_command_gen;

  localparam int TO = 100;

  logic              clk = 1'b0;
  logic              reset;
  logic              frame_valid;
  logic [15:0]       left_x, left_y, left_z, right_x, right_y, right_z;
  logic              cmd_valid;
  logic [7:0]        throttle;
  logic signed [7:0] roll, pitch;
  logic              armed;

  always #5 clk = ~clk;

  hand_command_gen #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid),
    .left_x(left_x), .left_y(left_y), .left_z(left_z),
    .right_x(right_x), .right_y(right_y), .right_z(right_z),
    .cmd_valid(cmd_valid), .throttle(throttle), .roll(roll), .pitch(pitch),
    .armed(armed)
  );

  typedef struct {
    int         cyc;
    logic [7:0] thr;
    logic [7:0] rol;
    logic [7:0] pit;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_fc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest expected command
  always @(negedge clk) begin
    exp_t e;
    if (cmd_valid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_cmd cyc=%0d got thr=%0d roll=%0d pitch=%0d required no command",
                 cyc, throttle, roll, pitch);
      end else begin
        e = sb.pop_front();
        if (cyc != e.cyc || throttle !== e.thr || roll !== e.rol || pitch !== e.pit) begin
          n_bad++;
          $display("FAIL cmd got cyc=%0d thr=%0d roll=%0d pitch=%0d required cyc=%0d thr=%0d roll=%0d pitch=%0d",
                   cyc, throttle, roll, pitch, e.cyc, e.thr, $signed(e.rol), $signed(e.pit));
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  // One-cycle frame strobe; optionally queue the command expected two cycles later
  task automatic send(input int ly, input int ry, input int lz, input int rz,
                      input bit ex, input int et, input int er, input int ep);
    left_y  = 16'(ly);
    right_y = 16'(ry);
    left_z  = 16'(lz);
    right_z = 16'(rz);
    left_x  = 16'(cyc);
    right_x = ~16'(cyc);
    frame_valid = 1'b1;
    last_fc = cyc;
    if (ex) sb.push_back(exp_t'{cyc + 2, 8'(et), 8'(er), 8'(ep)});
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    frame_valid = 1'b0;
    left_x = '0; left_y = '0; left_z = '0;
    right_x = '0; right_y = '0; right_z = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_valid", int'(cmd_valid), 0);
    check("rst_throttle", int'(throttle), 0);
    check("rst_roll", int'(roll), 0);
    check("rst_pitch", int'(pitch), 0);
    check("rst_armed", int'(armed), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Arming: seven silent frames, eighth yields the first command
    for (int i = 0; i < 7; i++) send(100, 100, 2048, 2048, 0, 0, 0, 0);
    check("armed_during_arming", int'(armed), 0);
    send(100, 100, 2048, 2048, 1, 206, 0, 0);
    check("armed_after_arming", int'(armed), 1);

    // ACTIVE vectors, back to back
    send(600, 200, 2048, 2048, 1, 156, 0, 0);       // left dead -> substituted
    send(300, 100, 2048, 2048, 1, 156, 50, 0);
    send(100, 100, 65535, 65535, 1, 206, 0, 127);   // pitch clamps high
    send(100, 100, 0, 0, 1, 206, 0, -127);          // -128 clamps to -127
    send(511, 0, 2048, 2048, 1, 128, 127, 0);       // roll clamps high
    send(0, 511, 2048, 2048, 1, 128, -127, 0);      // roll -128 clamps
    send(0, 0, 2048, 2048, 1, 255, 0, 0);           // throttle 256 clamps
    send(200, 100, 3000, 1000, 1, 181, 25, -3);
    send(100, 700, 2064, 2064, 1, 206, 0, 1);       // right dead -> substituted

    // Watchdog: hover command 101 cycles after the last frame
    sb.push_back(exp_t'{last_fc + TO + 1, 8'd128, 8'd0, 8'd0});
    repeat (TO + 10) @(posedge clk);
    #1;
    check("armed_in_hover", int'(armed), 1);
    send(100, 100, 2048, 2048, 1, 206, 0, 0);

    // Frame on exactly the expiry cycle suppresses hover and restarts watchdog
    repeat (TO - 1) @(posedge clk);
    #1;
    send(200, 200, 2048, 2048, 1, 156, 0, 0);
    sb.push_back(exp_t'{last_fc + TO + 1, 8'd128, 8'd0, 8'd0});
    repeat (TO + 10) @(posedge clk);
    #1;

    // Disarm: a live frame breaks the both-dead run, then four in a row disarm
    send(100, 100, 2048, 2048, 1, 206, 0, 0);
    send(700, 700, 3000, 3000, 1, 0, 0, 0);
    send(700, 700, 3000, 3000, 1, 0, 0, 0);
    send(100, 100, 2048, 2048, 1, 206, 0, 0);
    for (int i = 0; i < 3; i++) send(700, 700, 3000, 3000, 1, 0, 0, 0);
    check("armed_before_last_disarm", int'(armed), 1);
    send(700, 700, 3000, 3000, 1, 0, 0, 0);
    check("armed_after_disarm", int'(armed), 0);
    send(100, 100, 2048, 2048, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;

    // Abort arming: one arm-count-1 frame above, four more, then a dead frame
    for (int i = 0; i < 4; i++) send(100, 100, 2048, 2048, 0, 0, 0, 0);
    send(600, 600, 2048, 2048, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) send(100, 100, 2048, 2048, 0, 0, 0, 0);
    check("armed_after_abort_7", int'(armed), 0);
    send(100, 100, 2048, 2048, 1, 206, 0, 0);
    check("armed_after_rearm", int'(armed), 1);

    // Reset one cycle after a frame drops it in flight
    send(0, 0, 2048, 2048, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_cmd_valid", int'(cmd_valid), 0);
    check("midrst_throttle", int'(throttle), 0);
    check("midrst_roll", int'(roll), 0);
    check("midrst_pitch", int'(pitch), 0);
    check("midrst_armed", int'(armed), 0);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL missing_cmds got pending=%0d required=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hand_command_gen.md
# hand_command_gen

Converts the per-frame left/right hand coordinates from the hand-ordering stage into drone flight commands: throttle, roll and pitch. Sits directly downstream of the stage that sorts the two tracked hands into left and right. Adds an arm/disarm state machine, dead-zone handling, a loss-of-tracking watchdog and a two-stage arithmetic pipeline. Feeds the command serializer.

## Interface
- DEAD_Y, 512: y at or above this is the dead zone (bottom third; y grows downward)
- THR_SHIFT, 1: throttle right-shift
- ROLL_SHIFT, 2: roll right-shift
- PITCH_SHIFT, 4: pitch right-shift
- Z_CENTER, 2048: neutral depth
- ARM_FRAMES, 8: consecutive qualifying frames needed to arm
- DISARM_FRAMES, 4: consecutive both-dead frames needed to disarm
- TIMEOUT_CYCLES, 6500000: cycles without a frame before hover
- HOVER_THR, 128: throttle sent on timeout

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_valid  in  1  one-cycle strobe; hand coordinates valid this cycle
- left_x, left_y, left_z, right_x, right_y, right_z  in  16 each  unsigned hand coordinates
- cmd_valid  out  1  one-cycle strobe; command outputs valid
- throttle  out  8  unsigned, 0..255
- roll  out  8  signed two's complement, -127..127; positive = roll right
- pitch  out  8  signed, -127..127; positive = hand farther than Z_CENTER
- armed  out  1  high in ACTIVE and HOVER

## Operation
- States: IDLE, ARMING, ACTIVE, HOVER.
- A hand is "dead" when its y >= DEAD_Y. Per frame (stage 1, registered):
  - If exactly one hand is dead, its y is replaced by the other hand's y.
  - bothdead is set when both hands are dead.
- Stage 2 arithmetic, using 18-bit signed intermediates, registered:
  - avg_y = (ly+ry)>>1
  - throttle = sat_u8((DEAD_Y-avg_y)>>>THR_SHIFT)
  - roll = sat_s8((ly-ry)>>>ROLL_SHIFT)
  - pitch = sat_s8((((lz+rz)>>1)-Z_CENTER)>>>PITCH_SHIFT)
  - If bothdead, all three are 0.
  - Saturation clamps to [0,255] for throttle and [-127,127] for roll/pitch. -128 is never produced.
- IDLE: no cmd_valid. A frame with both hands not dead moves to ARMING with arm count 1.
- ARMING:
  - Each qualifying frame increments the count. On reaching ARM_FRAMES, go to ACTIVE; that frame produces the first command.
  - Any non-qualifying frame returns to IDLE and clears the count. No commands are issued in ARMING.
- ACTIVE:
  - Every frame produces a command.
  - DISARM_FRAMES consecutive bothdead frames go to IDLE. The last of these still emits its all-zero command.
  - A non-bothdead frame clears the disarm count.
- Watchdog:
  - Counts cycles since the last frame_valid while in ACTIVE.
  - At TIMEOUT_CYCLES, go to HOVER and emit one command: throttle=HOVER_THR, roll=0, pitch=0.
- HOVER:
  - The next frame_valid returns to ACTIVE and is processed normally. The watchdog restarts.
  - The disarm count holds its value.
- The watchdog is cleared on any frame_valid and is inactive outside ACTIVE.

## Timing
- Latency: frame_valid in cycle N gives cmd_valid in cycle N+2. Throughput is one frame per cycle, with back-to-back strobes accepted.
- Outputs hold their values between cmd_valid strobes.
- Hover command: cmd_valid occurs 1 cycle after the watchdog reaches TIMEOUT_CYCLES.
- If frame_valid arrives in the same cycle the watchdog expires, the frame wins: no hover command and the watchdog is cleared.
- If a pipelined frame command and a hover command would collide, the frame command takes priority.
- Reset, including mid-pipeline:
  - Next cycle: state IDLE; all counters 0; in-flight frames dropped.
  - Outputs: cmd_valid=0, throttle=0, roll=0, pitch=0, armed=0.
- State transitions take effect on the stage-1 register edge. armed changes 1 cycle after the deciding frame_valid.

## Configuration
- HAND_CMD_SMOOTH_EN defined:
  - Throttle, roll and pitch each pass through a 4-tap moving average: sum of the last 4 ACTIVE-frame values, >>>2.
  - This adds one register stage, so latency is N+3.
  - History is preloaded with the first sample on entry to ACTIVE from ARMING or HOVER.
  - The hover command and bothdead zeros bypass the filter and do not enter the history.
- Undefined: no filter, latency N+2.

## Test plan
- Arming: 8 frames with ly=ry=100, lz=rz=2048 -> no cmd_valid for frames 1-7. Frame 8 gives cmd_valid 2 cycles later with throttle=206, roll=0, pitch=0, armed=1.
- Abort arming: 5 qualifying frames, then ly=ry=600, then 8 qualifying frames -> the first command comes at the 8th frame after the abort.
- Dead-zone substitution, ACTIVE: ly=600, ry=200 -> throttle=156, roll=0.
  - Then ly=300, ry=100 -> roll=50, throttle=156.
- Saturation: lz=rz=65535 -> pitch=127. lz=rz=0 -> pitch=-127.
- Watchdog (TIMEOUT_CYCLES=100): in ACTIVE, no frames -> one cmd_valid with throttle=128, roll=0, pitch=0 at 101 cycles after the last frame_valid.
  - Next frame returns armed=1 with a normal command.
  - A frame exactly on cycle 100 suppresses the hover command.
- Disarm/reset: 4 frames with ly=ry=700 -> four all-zero commands, then armed=0. reset asserted 1 cycle after a frame_valid -> no cmd_valid; all outputs 0.
